// File: rtl/alg_pkg.sv
// Shared types for the ECG detection path: sample type, ADC truncation slice
// and the ADC sampler state encoding.
package alg_pkg;

    localparam int ECG_SAMPLE_W   = 11;
    localparam int ADC_SAMPLE_MSB = 15;
    localparam int ADC_SAMPLE_LSB = 5;

    typedef logic [ECG_SAMPLE_W-1:0] ecg_sample;

    typedef enum logic [1:0] {
        IDLE,
        CONVST,
        WAIT_BUSY,
        WAIT_DATA
    } adc_samp_state_t;

    // XADC left-justifies its 12-bit result; keep the top 11 bits.
    function automatic ecg_sample adc_to_sample(input logic [15:0] tdata);
        return tdata[ADC_SAMPLE_MSB:ADC_SAMPLE_LSB];
    endfunction

endpackage

// File: rtl/rate_tick_gen.sv
// Free-running divide-by-DIV counter gated by an enable; one-cycle tick on the
// last count. Counter is parked at zero while disabled.
module rate_tick_gen #(
    parameter int DIV = 16
) (
    input  logic i_clk,
    input  logic i_nrst,
    input  logic i_en,
    output logic o_tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = '0;
        if (i_en && (cnt_q != LAST)) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

    assign o_tick = i_en && (cnt_q == LAST);

endmodule

// File: rtl/ecg_adc_sampler.sv
// Paces XADC conversions at the ECG sample rate, captures the resulting stream
// beat as an ecg_sample and flags overrun/timeout conditions.
module ecg_adc_sampler
    import alg_pkg::*;
#(
    parameter int CLK_HZ         = 100_000_000,
    parameter int SAMPLE_HZ      = 360,
    parameter int CONVST_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        i_clk,
    input  logic        i_nrst,
    input  logic        i_en,
    input  logic        i_clr_status,
    output logic        o_adc_convst,
    input  logic        i_adc_busy,
    input  logic        i_adc_tvalid,
    output logic        o_adc_tready,
    input  logic [15:0] i_adc_tdata,
    output ecg_sample   o_sample,
    output logic        o_sample_vld,
    output logic [15:0] o_sample_cnt,
    output logic        o_overrun,
    output logic        o_timeout
);

    localparam int DIV = CLK_HZ / SAMPLE_HZ;
    localparam int CCW = $clog2(CONVST_CYCLES + 1);
    localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);

    adc_samp_state_t state_q, state_d;
    logic            convst_q, convst_d;
    logic            tready_q, tready_d;
    ecg_sample       sample_q, sample_d;
    logic            sample_vld_q, sample_vld_d;
    logic [15:0]     sample_cnt_q, sample_cnt_d;
    logic            overrun_q, overrun_d;
    logic            timeout_q, timeout_d;
    logic [CCW-1:0]  cc_q, cc_d;
    logic [TCW-1:0]  tc_q, tc_d;

    logic tick, accept, ovr_set, to_set;

    rate_tick_gen #(.DIV(DIV)) u_rate (
        .i_clk  (i_clk),
        .i_nrst (i_nrst),
        .i_en   (i_en),
        .o_tick (tick)
    );

    // Ready tracks enable only, so every beat is taken; state decides its fate.
    assign accept = i_adc_tvalid && tready_q;

    always_comb begin
        state_d      = state_q;
        convst_d     = convst_q;
        cc_d         = cc_q;
        tc_d         = tc_q;
        sample_d     = sample_q;
        sample_vld_d = 1'b0;
        sample_cnt_d = sample_cnt_q;
        tready_d     = i_en;
        ovr_set      = 1'b0;
        to_set       = 1'b0;

        if (!i_en) begin
            state_d  = IDLE;
            convst_d = 1'b0;
            cc_d     = '0;
            tc_d     = '0;
        end else begin
            if (tick && (state_q != IDLE)) ovr_set = 1'b1;
            unique case (state_q)
                IDLE: begin
                    if (accept) ovr_set = 1'b1;
                    if (tick) begin
                        state_d  = CONVST;
                        convst_d = 1'b1;
                        cc_d     = '0;
                    end
                end
                CONVST: begin
                    if (accept) ovr_set = 1'b1;
                    if (cc_q == CCW'(CONVST_CYCLES - 1)) begin
                        state_d  = WAIT_BUSY;
                        convst_d = 1'b0;
                        tc_d     = '0;
                    end else begin
                        cc_d = cc_q + 1'b1;
                    end
                end
                WAIT_BUSY, WAIT_DATA: begin
                    tc_d = tc_q + 1'b1;
                    // A beat before busy is a fast conversion and is still valid data.
                    if (accept) begin
                        sample_d     = adc_to_sample(i_adc_tdata);
                        sample_vld_d = 1'b1;
                        sample_cnt_d = sample_cnt_q + 16'd1;
                        state_d      = IDLE;
                    end else if (tc_d == TCW'(TIMEOUT_CYCLES)) begin
                        to_set  = 1'b1;
                        state_d = IDLE;
                    end else if ((state_q == WAIT_BUSY) && i_adc_busy) begin
                        state_d = WAIT_DATA;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // Set beats a simultaneous clear.
        overrun_d = ovr_set || (overrun_q && !i_clr_status);
        timeout_d = to_set  || (timeout_q && !i_clr_status);
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_q      <= IDLE;
            convst_q     <= 1'b0;
            tready_q     <= 1'b0;
            sample_q     <= '0;
            sample_vld_q <= 1'b0;
            sample_cnt_q <= '0;
            overrun_q    <= 1'b0;
            timeout_q    <= 1'b0;
            cc_q         <= '0;
            tc_q         <= '0;
        end else begin
            state_q      <= state_d;
            convst_q     <= convst_d;
            tready_q     <= tready_d;
            sample_q     <= sample_d;
            sample_vld_q <= sample_vld_d;
            sample_cnt_q <= sample_cnt_d;
            overrun_q    <= overrun_d;
            timeout_q    <= timeout_d;
            cc_q         <= cc_d;
            tc_q         <= tc_d;
        end
    end

    assign o_adc_convst = convst_q;
    assign o_adc_tready = tready_q;
    assign o_sample     = sample_q;
    assign o_sample_vld = sample_vld_q;
    assign o_sample_cnt = sample_cnt_q;
    assign o_overrun    = overrun_q;
    assign o_timeout    = timeout_q;

endmodule
